// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM modulator: PCM samples in over valid/ready, OSR PDM bits out per sample.
// Optional saturating underrun counter port enabled by defining PDM_UNDERRUN_CNT_EN.
module pdm_modulator #(
  parameter int DATA_W  = 7,
  parameter int CLK_DIV = 50,
  parameter int OSR     = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              pdm_clk,
  output logic              pdm_data,
  output logic              underrun
`ifdef PDM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DATA_W:0]  MAX      = {1'b0, {DATA_W{1'b1}}};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W:0]   err;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] hold_buf;
  logic              buf_full;

  logic              tick;
  logic              boundary;
  logic              load;
  logic              accept;
  logic              miss;
  logic              bit_one;
  logic [DATA_W-1:0] d_sel;
  logic [DIV_W-1:0]  div_nxt;
  logic [DATA_W:0]   err_nxt;

  assign s_ready = !buf_full;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    tick     = 1'b0;
    boundary = 1'b0;
    load     = 1'b0;
    miss     = 1'b0;
    accept   = s_valid && !buf_full;
    d_sel    = cur;
    div_nxt  = div_cnt + 1'b1;
    bit_one  = 1'b0;
    err_nxt  = err;

    if (en && (div_cnt == DIV_LAST)) begin
      tick    = 1'b1;
      div_nxt = '0;
    end
    if (tick && (bit_cnt == '0)) begin
      boundary = 1'b1;
      load     = buf_full;
      miss     = !buf_full;
    end
    // The boundary step modulates the sample being loaded this cycle, not the old one.
    if (load) begin
      d_sel = hold_buf;
    end

    // err stays within [0, MAX]: either branch keeps it non-negative and bounded.
    if ({1'b0, d_sel} >= err) begin
      bit_one = 1'b1;
      err_nxt = err + MAX - {1'b0, d_sel};
    end else begin
      err_nxt = err - {1'b0, d_sel};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      err      <= '0;
      cur      <= '0;
      hold_buf <= '0;
      buf_full <= 1'b0;
      pdm_clk  <= 1'b0;
      pdm_data <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // The holding buffer and handshake keep working while the modulator is disabled.
      if (accept) begin
        hold_buf <= s_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      if (load) begin
        cur <= hold_buf;
      end
      underrun <= miss;

      if (!en) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        err      <= '0;
        pdm_clk  <= 1'b0;
        pdm_data <= 1'b0;
      end else begin
        div_cnt <= div_nxt;
        pdm_clk <= (div_nxt < DIV_HALF);
        if (tick) begin
          bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          pdm_data <= bit_one;
          err      <= err_nxt;
        end
      end
    end
  end

`ifdef PDM_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (miss && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
